// File: rtl/student_fir_tlul_host_pkg.sv
// TL-UL channel types, opcodes and FSM state codes shared by the FIR TL-UL host slice.
package student_fir_tlul_host_pkg;

    localparam logic [2:0] TL_PUT_FULL_DATA   = 3'h0;
    localparam logic [2:0] TL_GET             = 3'h4;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'h0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'h1;
    localparam logic [1:0] TL_SIZE_WORD       = 2'd2;
    localparam logic [3:0] TL_MASK_WORD       = 4'hF;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_WR_REQ   = 4'd1;
    localparam logic [3:0] ST_WR_RSP   = 4'd2;
    localparam logic [3:0] ST_STROBE   = 4'd3;
    localparam logic [3:0] ST_GAP      = 4'd4;
    localparam logic [3:0] ST_WAIT_FIR = 4'd5;
    localparam logic [3:0] ST_RD_REQ   = 4'd6;
    localparam logic [3:0] ST_RD_RSP   = 4'd7;
    localparam logic [3:0] ST_OUT      = 4'd8;

endpackage

// File: rtl/student_fir_tlul_host_if.sv
// TL-UL request/response channel pair between the FIR host and the crossbar port.
interface student_fir_tlul_host_if;
    import student_fir_tlul_host_pkg::*;

    tl_h2d_t h2d;
    tl_d2h_t d2h;

    modport master (output h2d, input d2h);
    modport slave  (input h2d, output d2h);

endinterface

// File: rtl/student_fir_tlul_host.sv
// TL-UL initiator: writes each sample to the FIR, strobes it, waits for done, reads y_out back.
// Optional watchdog on the wait states: define STUDENT_FIR_TLUL_HOST_TIMEOUT_EN.
module student_fir_tlul_host
    import student_fir_tlul_host_pkg::*;
#(
    parameter int          DATA_SIZE         = 16,
    parameter int          DATA_SIZE_FIR_OUT = 24,
    parameter logic [31:0] REG_BASE_ADDR     = 32'h0002_0000,
    parameter logic [31:0] SAMPLE_OFS        = 32'h0,
    parameter logic [31:0] YOUT_OFS          = 32'h8,
    parameter int          STROBE_CYCLES     = 2,
    parameter int          TIMEOUT_CYCLES    = 4096
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         sample_valid_i,
    output logic                         sample_ready_o,
    input  logic [DATA_SIZE-1:0]         sample_i,
    output logic                         fir_strobe_o,
    input  logic                         fir_valid_i,
    output logic                         result_valid_o,
    input  logic                         result_ready_i,
    output logic [DATA_SIZE_FIR_OUT-1:0] result_o,
    output logic                         err_o,
    output logic                         busy_o,
    student_fir_tlul_host_if.master      tl
);

    localparam int STROBE_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    logic [3:0]                   state_q, state_d;
    logic [DATA_SIZE-1:0]         sample_q;
    logic [DATA_SIZE_FIR_OUT-1:0] result_q;
    logic [STROBE_W-1:0]          strobe_cnt_q;
    logic                         err_q;
    logic                         ready_q;
    logic                         in_rsp;
    logic                         d_hs;
    logic                         timeout;

    assign in_rsp = (state_q == ST_WR_RSP) || (state_q == ST_RD_RSP);
    assign d_hs   = in_rsp && !timeout && tl.d2h.d_valid;

`ifdef STUDENT_FIR_TLUL_HOST_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] timer_q;
    logic               in_wait;

    assign in_wait = in_rsp || (state_q == ST_WAIT_FIR);
    assign timeout = in_wait && (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    // Restart the count on every state change so each wait state gets the full budget.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= '0;
        end else if (!in_wait || (state_d != state_q)) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        if (timeout) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:     if (sample_valid_i && ready_q) state_d = ST_WR_REQ;
                ST_WR_REQ:   if (tl.d2h.a_ready) state_d = ST_WR_RSP;
                ST_WR_RSP:   if (d_hs) state_d = ST_STROBE;
                ST_STROBE:   if (strobe_cnt_q == STROBE_W'(STROBE_CYCLES - 1)) state_d = ST_GAP;
                ST_GAP:      state_d = ST_WAIT_FIR;
                ST_WAIT_FIR: if (fir_valid_i) state_d = ST_RD_REQ;
                ST_RD_REQ:   if (tl.d2h.a_ready) state_d = ST_RD_RSP;
                ST_RD_RSP:   if (d_hs) state_d = ST_OUT;
                ST_OUT:      if (result_ready_i) state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // A-channel fields depend only on state and the registered sample, so they hold while stalled.
    always_comb begin
        tl.h2d         = '0;
        tl.h2d.d_ready = in_rsp && !timeout;
        if ((state_q == ST_WR_REQ) || (state_q == ST_RD_REQ)) begin
            tl.h2d.a_valid = 1'b1;
            tl.h2d.a_size  = TL_SIZE_WORD;
            tl.h2d.a_mask  = TL_MASK_WORD;
        end
        if (state_q == ST_WR_REQ) begin
            tl.h2d.a_opcode  = TL_PUT_FULL_DATA;
            tl.h2d.a_address = REG_BASE_ADDR + SAMPLE_OFS;
            tl.h2d.a_data    = 32'(sample_q);
        end
        if (state_q == ST_RD_REQ) begin
            tl.h2d.a_opcode  = TL_GET;
            tl.h2d.a_address = REG_BASE_ADDR + YOUT_OFS;
        end
    end

    // NOTE: all state updates are non-blocking so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b0;
            sample_q     <= '0;
            result_q     <= '0;
            strobe_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= (state_d == ST_IDLE);
            strobe_cnt_q <= (state_q == ST_STROBE) ? strobe_cnt_q + 1'b1 : '0;
            if ((state_q == ST_IDLE) && (state_d == ST_WR_REQ)) begin
                sample_q <= sample_i;
            end
            if ((state_q == ST_RD_RSP) && d_hs) begin
                result_q <= tl.d2h.d_data[DATA_SIZE_FIR_OUT-1:0];
            end
            if ((d_hs && tl.d2h.d_error) || timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    // Ready is registered so it stays low during reset and for the cycle a result is taken.
    assign sample_ready_o = ready_q && (state_q == ST_IDLE);
    assign fir_strobe_o   = (state_q == ST_STROBE);
    assign result_valid_o = (state_q == ST_OUT);
    assign result_o       = result_q;
    assign err_o          = err_q;
    assign busy_o         = (state_q != ST_IDLE);

    logic unused_tl;
    assign unused_tl = ^{tl.d2h.d_opcode, tl.d2h.d_size, tl.d2h.d_source,
                         tl.d2h.d_data[31:DATA_SIZE_FIR_OUT]};

endmodule
